// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle sequencing FSM for a simple load/store core.
// Walks FETCH -> DECODE -> EXECUTE/BRANCH -> WRITEBACK and drives datapath
// strobes from the registered state (plus instr_valid while fetching).
// Optional feature: define CPU_CONTROLLER_PERF_EN to add the 32-bit
// 'retired' instruction counter output.
module cpu_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [3:0]  cond,
    input  logic        en_status,
    input  logic [3:0]  nzcv,
    input  logic        instr_valid,
    output logic        instr_req,
    output logic        load_ir,
    output logic        load_pc,
    output logic        load_a,
    output logic        load_b,
    output logic        load_s,
    output logic        load_c,
    output logic        w_en,
    output logic        sel_pc,
    output logic        sel_w,
    output logic        en_status_out,
    output logic        halted
`ifdef CPU_CONTROLLER_PERF_EN
    ,
    output logic [31:0] retired
`endif
);

    localparam logic [6:0] OP_HALT = 7'b0000001;
    localparam logic [3:0] OP_CMP  = 4'b1010;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_BRANCH,
        S_HALTED
    } state_e;

    state_e state_q, state_d;

    // Instruction attributes captured in DECODE so later strobes depend only
    // on registered values.
    logic cmp_q, link_q, s_q;

    logic cond_pass;
    logic is_halt;

    // ARM condition-code evaluation against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        unique case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = cy;
            4'b0011: cond_eval = !cy;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = cy && !z;
            4'b1001: cond_eval = !cy || z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = !z && (n == v);
            4'b1101: cond_eval = z || (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign cond_pass = cond_eval(cond, nzcv);
    assign is_halt   = (opcode == OP_HALT);

    // State register; reset returns to FETCH from any state, HALTED included.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Latch the instruction attributes needed after DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q  <= 1'b0;
            link_q <= 1'b0;
            s_q    <= 1'b0;
        end else if (state_q == S_DECODE) begin
            cmp_q  <= (opcode[3:0] == OP_CMP);
            link_q <= opcode[2];
            s_q    <= en_status;
        end
    end

    // Next-state and strobe decode; reset forces every output low.
    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        instr_req     = 1'b0;
        load_ir       = 1'b0;
        load_pc       = 1'b0;
        load_a        = 1'b0;
        load_b        = 1'b0;
        load_s        = 1'b0;
        load_c        = 1'b0;
        w_en          = 1'b0;
        sel_pc        = 1'b0;
        sel_w         = 1'b0;
        en_status_out = 1'b0;
        halted        = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    load_ir = 1'b1;
                    load_pc = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                load_a = 1'b1;
                load_b = 1'b1;
                load_s = 1'b1;
                if (is_halt)         state_d = S_HALTED;
                else if (!cond_pass) state_d = S_FETCH;
                else if (opcode[6])  state_d = S_BRANCH;
                else                 state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                load_c        = 1'b1;
                en_status_out = cmp_q | s_q;
                state_d       = cmp_q ? S_FETCH : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                w_en    = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                load_pc = 1'b1;
                sel_pc  = 1'b1;
                w_en    = link_q;
                sel_w   = link_q;
                state_d = S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            instr_req     = 1'b0;
            load_ir       = 1'b0;
            load_pc       = 1'b0;
            load_a        = 1'b0;
            load_b        = 1'b0;
            load_s        = 1'b0;
            load_c        = 1'b0;
            w_en          = 1'b0;
            sel_pc        = 1'b0;
            sel_w         = 1'b0;
            en_status_out = 1'b0;
            halted        = 1'b0;
        end
    end

`ifdef CPU_CONTROLLER_PERF_EN
    logic [31:0] retired_q;
    logic        retire;

    // An instruction retires on WRITEBACK, BRANCH, CMP in EXECUTE, or when
    // its condition fails in DECODE (HALT never retires).
    assign retire = ((state_q == S_DECODE) && !is_halt && !cond_pass)
                  || (state_q == S_WRITEBACK)
                  || (state_q == S_BRANCH)
                  || ((state_q == S_EXECUTE) && cmp_q);

    // Free-running retire counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst)         retired_q <= 32'd0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign retired = rst ? 32'd0 : retired_q;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: instruction-level reference model expands each
// instruction into its expected per-cycle output trace; one compare process
// checks the DUT against that trace every cycle.
module tb_cpu_controller;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] opcode;
    logic [3:0] cond;
    logic       en_status;
    logic [3:0] nzcv;
    logic       instr_valid;
    logic instr_req, load_ir, load_pc, load_a, load_b, load_s, load_c;
    logic w_en, sel_pc, sel_w, en_status_out, halted;
`ifdef CPU_CONTROLLER_PERF_EN
    logic [31:0] retired;
`endif

    cpu_controller dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .cond          (cond),
        .en_status     (en_status),
        .nzcv          (nzcv),
        .instr_valid   (instr_valid),
        .instr_req     (instr_req),
        .load_ir       (load_ir),
        .load_pc       (load_pc),
        .load_a        (load_a),
        .load_b        (load_b),
        .load_s        (load_s),
        .load_c        (load_c),
        .w_en          (w_en),
        .sel_pc        (sel_pc),
        .sel_w         (sel_w),
        .en_status_out (en_status_out),
        .halted        (halted)
`ifdef CPU_CONTROLLER_PERF_EN
        ,
        .retired       (retired)
`endif
    );

    typedef struct packed {
        logic instr_req, load_ir, load_pc, load_a, load_b, load_s;
        logic load_c, w_en, sel_pc, sel_w, en_status_out, halted;
    } outs_t;

    typedef struct packed {
        outs_t       o;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        logic  valid;
        outs_t o;
        bit    retire;
    } step_t;

    localparam logic [6:0] OP_HALT = 7'b0000001;
    localparam logic [6:0] OP_ADD  = 7'b0011000;
    localparam logic [6:0] OP_CMP  = 7'b0001010;
    localparam logic [6:0] OP_BL   = 7'b1000100;
    localparam logic [6:0] OP_B    = 7'b1000000;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ret = 32'd0;

    // Running totals of observed strobe activity, used by directed checks.
    int act_req = 0, act_ir = 0, act_pc = 0, act_wen = 0, act_c = 0;
    int act_ens = 0, act_selpc = 0, act_halt = 0;

    outs_t act;
    assign act = {instr_req, load_ir, load_pc, load_a, load_b, load_s,
                  load_c, w_en, sel_pc, sel_w, en_status_out, halted};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ARM condition table, straight from the architectural definition.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;                 // EQ
            4'h1: return !z;                // NE
            4'h2: return cy;                // CS
            4'h3: return !cy;               // CC
            4'h4: return n;                 // MI
            4'h5: return !n;                // PL
            4'h6: return v;                 // VS
            4'h7: return !v;                // VC
            4'h8: return cy && !z;          // HI
            4'h9: return !cy || z;          // LS
            4'hA: return n == v;            // GE
            4'hB: return n != v;            // LT
            4'hC: return !z && (n == v);    // GT
            4'hD: return z || (n != v);     // LE
            4'hE: return 1'b1;              // AL
            default: return 1'b0;           // NV
        endcase
    endfunction

    // Compare process: one expected trace entry per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", 64'(act), 64'(e.o));
`ifdef CPU_CONTROLLER_PERF_EN
                check("retired", 64'(retired), 64'(e.ret));
`endif
            end
            act_req   += int'(instr_req);
            act_ir    += int'(load_ir);
            act_pc    += int'(load_pc);
            act_wen   += int'(w_en);
            act_c     += int'(load_c);
            act_ens   += int'(en_status_out);
            act_selpc += int'(sel_pc);
            act_halt  += int'(halted);
        end
    end

    task automatic drive_cycle(input logic r, input logic v, input outs_t o, input logic [31:0] ret);
        exp_t x;
        rst         = r;
        instr_valid = v;
        x.o   = o;
        x.ret = ret;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        drive_cycle(1'b1, v, '0, 32'd0);
        model_ret = 32'd0;
    endtask

    // Build the expected trace of one instruction, then play it; abort_at
    // (if inside the trace) replaces that cycle with a reset pulse.
    task automatic run_instr(input logic [6:0] op, input logic [3:0] cd, input logic [3:0] f,
                             input logic s, input int wait_n, input int abort_at, input int halt_hold);
        step_t plan[$];
        step_t st;
        bit    pass, cmp;
        opcode = op; cond = cd; nzcv = f; en_status = s;
        for (int i = 0; i < wait_n; i++) begin
            st.valid = 1'b0; st.o = '0; st.o.instr_req = 1'b1; st.retire = 0;
            plan.push_back(st);
        end
        st.valid = 1'b1; st.o = '0; st.retire = 0;
        st.o.instr_req = 1'b1; st.o.load_ir = 1'b1; st.o.load_pc = 1'b1;
        plan.push_back(st);
        pass = ref_cond(cd, f);
        st.valid = 1'($urandom); st.o = '0;
        st.o.load_a = 1'b1; st.o.load_b = 1'b1; st.o.load_s = 1'b1;
        st.retire = (op != OP_HALT) && !pass;
        plan.push_back(st);
        if (op == OP_HALT) begin
            for (int h = 0; h < halt_hold; h++) begin
                st.valid = 1'($urandom); st.o = '0; st.o.halted = 1'b1; st.retire = 0;
                plan.push_back(st);
            end
        end else if (pass && op[6]) begin
            st.valid = 1'($urandom); st.o = '0; st.retire = 1;
            st.o.load_pc = 1'b1; st.o.sel_pc = 1'b1;
            st.o.w_en = op[2]; st.o.sel_w = op[2];
            plan.push_back(st);
        end else if (pass) begin
            cmp = (op[3:0] == 4'b1010);
            st.valid = 1'($urandom); st.o = '0; st.retire = cmp;
            st.o.load_c = 1'b1; st.o.en_status_out = cmp || s;
            plan.push_back(st);
            if (!cmp) begin
                st.valid = 1'($urandom); st.o = '0; st.retire = 1; st.o.w_en = 1'b1;
                plan.push_back(st);
            end
        end
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                do_reset(1'b1);
                return;
            end
            drive_cycle(1'b0, plan[i].valid, plan[i].o, model_ret);
            if (plan[i].retire) model_ret = model_ret + 32'd1;
        end
    endtask

    initial begin
        int r0, i0, w0, c0, e0, p0, h0, l0;
        logic [6:0] op;
        int sel;
        rst = 1'b1; opcode = '0; cond = '0; en_status = 1'b0; nzcv = '0; instr_valid = 1'b0;
        do_reset(1'b0);

        // Fetch wait of 5 cycles, then ADD (always).
        r0 = act_req; i0 = act_ir; w0 = act_wen; c0 = act_c;
        run_instr(OP_ADD, 4'b1110, 4'($urandom), 1'b0, 5, -1, 0);
        check("fetch_wait_req_cycles", 64'(act_req - r0), 64'd6);
        check("fetch_wait_ir_pulses", 64'(act_ir - i0), 64'd1);
        check("add_load_c", 64'(act_c - c0), 64'd1);
        check("add_w_en", 64'(act_wen - w0), 64'd1);

        // ADD with immediate instr_valid.
        w0 = act_wen;
        run_instr(OP_ADD, 4'b1110, 4'b0000, 1'b1, 0, -1, 0);
        check("add_imm_w_en", 64'(act_wen - w0), 64'd1);

        // CMP with S bit clear still updates flags, no writeback.
        w0 = act_wen; e0 = act_ens;
        run_instr(OP_CMP, 4'b1110, 4'b0000, 1'b0, 0, -1, 0);
        check("cmp_no_w_en", 64'(act_wen - w0), 64'd0);
        check("cmp_en_status_out", 64'(act_ens - e0), 64'd1);

        // BL EQ taken (Z set) and skipped (Z clear).
        w0 = act_wen; p0 = act_selpc;
        run_instr(OP_BL, 4'b0000, 4'b0100, 1'b0, 1, -1, 0);
        check("bl_taken_w_en", 64'(act_wen - w0), 64'd1);
        check("bl_taken_sel_pc", 64'(act_selpc - p0), 64'd1);
        w0 = act_wen; p0 = act_selpc; l0 = act_pc;
        run_instr(OP_BL, 4'b0000, 4'b0000, 1'b0, 0, -1, 0);
        check("bl_skip_w_en", 64'(act_wen - w0), 64'd0);
        check("bl_skip_sel_pc", 64'(act_selpc - p0), 64'd0);
        check("bl_skip_load_pc", 64'(act_pc - l0), 64'd1);

        // HALT under NV condition still halts; reset recovers.
        h0 = act_halt;
        run_instr(OP_HALT, 4'b1111, 4'($urandom), 1'b0, 0, -1, 4);
        check("halt_cycles", 64'(act_halt - h0), 64'd4);
        do_reset(1'b1);
        r0 = act_req;
        run_instr(OP_ADD, 4'b1110, 4'b0000, 1'b0, 0, -1, 0);
        check("post_halt_fetch", 64'(act_req - r0), 64'd1);

        // Reset during the instr_valid cycle of a fetch must not load IR/PC.
        i0 = act_ir;
        run_instr(OP_ADD, 4'b1110, 4'b0000, 1'b0, 2, 2, 0);
        check("aborted_fetch_no_ir", 64'(act_ir - i0), 64'd0);

        // ADD, skipped B, CMP -> three retirements.
        do_reset(1'b0);
        run_instr(OP_ADD, 4'b1110, 4'b0000, 1'b0, 0, -1, 0);
        run_instr(OP_B, 4'b0000, 4'b0000, 1'b0, 0, -1, 0);
        run_instr(OP_CMP, 4'b1110, 4'b0000, 1'b0, 0, -1, 0);
`ifdef CPU_CONTROLLER_PERF_EN
        check("retired_three", 64'(retired), 64'd3);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      op = OP_HALT;
            else if (sel < 4)  op = {1'b1, 6'($urandom)};
            else if (sel < 6)  op = {1'b0, 2'($urandom), 4'b1010};
            else begin
                op = {1'b0, 6'($urandom)};
                if (op == OP_HALT) op = 7'b0000010;
            end
            run_instr(op, 4'($urandom), 4'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1,
                      int'($urandom_range(1, 3)));
            if (op == OP_HALT) do_reset(1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The module SHALL have the port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 The module SHALL have the port rst  input  1  reset, synchronous and active-high.
REQ-003 The module SHALL have the port opcode  input  7  decoded opcode from the instruction decoder.
REQ-004 The module SHALL have the port cond  input  4  instruction condition field.
REQ-005 The module SHALL have the port en_status  input  1  decoded S bit.
REQ-006 The module SHALL have the port nzcv  input  4  status flags {N,Z,C,V}.
REQ-007 The module SHALL have the port instr_valid  input  1  instruction memory returns data this cycle.
REQ-008 The module SHALL have the port instr_req  output  1  instruction fetch request.
REQ-009 The module SHALL have the ports load_ir, load_pc, load_a, load_b, load_s, load_c, w_en, sel_pc, sel_w, en_status_out  output  1 each  datapath strobes and selects.
REQ-010 The module SHALL have the port halted  output  1  core stopped.

Function
REQ-011 States SHALL be FETCH, DECODE, EXECUTE, WRITEBACK, BRANCH, HALTED; one-hot or binary encoding at implementer's choice.
REQ-012 FETCH: instr_req=1 each cycle until instr_valid=1; on that cycle load_ir=1, load_pc=1, sel_pc=0 (PC+4), next state DECODE.
REQ-013 DECODE: load_a=1, load_b=1, load_s=1 for one cycle; evaluate cond against nzcv.
REQ-014 Condition table SHALL be ARM standard: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110 always, 1111 never.
REQ-015 Condition false SHALL return DECODE->FETCH with no further strobes, except opcode 7'b0000001 which halts regardless of cond.
REQ-016 opcode 7'b0000001 SHALL transition DECODE->HALTED.
REQ-017 opcode[6]=1 SHALL transition DECODE->BRANCH; all other opcodes DECODE->EXECUTE.
REQ-018 EXECUTE: load_c=1; en_status_out=en_status; CMP (opcode[3:0]=4'b1010) forces en_status_out=1 and next state FETCH; otherwise next WRITEBACK.
REQ-019 WRITEBACK: w_en=1, sel_w=0 (ALU result); next FETCH.
REQ-020 BRANCH, one cycle: load_pc=1, sel_pc=1 (branch target); if opcode[2]=1 (BL/BLX) also w_en=1, sel_w=1 (link value to R14); next FETCH.
REQ-021 HALTED SHALL be absorbing until rst; halted=1, all strobes 0.
REQ-022 All strobes SHALL be Moore/Mealy-free of glitches: registered-state decode only, plus instr_valid in FETCH.
REQ-023 Latency: data op 4 cycles + fetch wait; CMP 3; branch 3; skipped instruction 2.
REQ-024 instr_valid outside FETCH SHALL be ignored.

Reset
REQ-025 rst=1 SHALL force state FETCH on the next edge, overriding any in-flight operation, including HALTED.
REQ-026 During and after rst cycle all outputs SHALL be 0 except instr_req, which is 1 from the first post-reset FETCH cycle.
REQ-027 A fetch aborted by rst SHALL not load IR or PC.

Configuration
REQ-028 Macro CPU_CONTROLLER_PERF_EN SHALL, when defined, add output retired  32  count of instructions completing WRITEBACK, BRANCH, or CMP-EXECUTE, plus skipped ones; reset to 0, wraps 32'hFFFFFFFF->0.
REQ-029 Without CPU_CONTROLLER_PERF_EN the port and counter SHALL not exist; behaviour otherwise identical.

Verification
REQ-030 Reset, instr_valid held 0 for 5 cycles then 1 -> instr_req high 6 cycles, load_ir/load_pc pulse once on 6th.
REQ-031 ADD reg (opcode 7'b0011000, cond 1110), instr_valid immediate -> load_ir, load_a/b/s, load_c, w_en on 4 consecutive cycles, then FETCH.
REQ-032 CMP imm (7'b0001010, en_status=0) -> en_status_out=1 in EXECUTE, no w_en, FETCH next.
REQ-033 BL (7'b1000100) with cond 0000, nzcv=4'b0100 -> BRANCH with load_pc, sel_pc=1, w_en, sel_w=1; with nzcv=0 -> skipped, no strobes.
REQ-034 HALT (7'b0000001, cond 1111) -> halted=1 indefinitely; rst pulse -> FETCH, halted=0.
REQ-035 With CPU_CONTROLLER_PERF_EN, 3 instructions (ADD, skipped B, CMP) -> retired=3.
